// File: rtl/fft_bitrev_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_bitrev_loader_if: sample-in / operand-pair-out stream bundle  (rev 1.0)
// ---------------------------------------------------------------------------
interface fft_bitrev_loader_if #(
   parameter int NBITS = 16,
   parameter int LOG2N = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [NBITS-1:0] in_re;
   logic signed [NBITS-1:0] in_im;

   logic                    out_valid;
   logic                    out_ready;
   logic signed [NBITS-1:0] out_ar;
   logic signed [NBITS-1:0] out_ai;
   logic signed [NBITS-1:0] out_br;
   logic signed [NBITS-1:0] out_bi;
   logic [LOG2N-2:0]        out_idx;
   logic                    out_last;

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_ar, out_ai, out_br, out_bi, out_idx, out_last
   );

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_ar, out_ai, out_br, out_bi, out_idx, out_last
   );
endinterface
`default_nettype wire

// File: rtl/fft_bitrev_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_bitrev_loader: ping-pong frame buffer emitting bit-reversed operand pairs
// revision 1.0
// ---------------------------------------------------------------------------
module fft_bitrev_loader #(
   parameter int NBITS = 16,
   parameter int LOG2N = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   fft_bitrev_loader_if.slave bus
);
   localparam int N  = 1 << LOG2N;
   localparam int W  = 2 * NBITS;
   localparam int CW = LOG2N - 1;
   localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
   localparam logic [CW-1:0]    RD_LAST = CW'(N / 2 - 1);

   typedef enum logic {
      FREE = 1'b0,
      FULL = 1'b1
   } bank_state_t;

   bank_state_t      bank_st    [2];
   bank_state_t      bank_st_nx [2];
   logic             wr_bank, wr_bank_nx;
   logic             rd_bank, rd_bank_nx;
   logic [LOG2N-1:0] wr_cnt, wr_cnt_nx;
   logic [CW-1:0]    rd_cnt, rd_cnt_nx;

   logic [W-1:0]     mem [2*N];

   logic                    ov;
   logic signed [NBITS-1:0] ar, ai, br, bi;
   logic [CW-1:0]           idx;
   logic                    last;

   logic             in_ready;
   logic             wr_fire;
   logic             load;
   logic             rd_avail;
   logic             rd_fire;
   logic [LOG2N-1:0] a_addr, b_addr;
   logic [W-1:0]     a_word, b_word;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   // Ready depends only on registered bank state, never on the handshakes.
   assign in_ready = (bank_st[wr_bank] == FREE);
   assign wr_fire  = bus.in_valid && in_ready;
   assign load     = !ov || bus.out_ready;
   assign rd_avail = (bank_st[rd_bank] == FULL);
   assign rd_fire  = load && rd_avail;

   assign a_addr = bitrev({rd_cnt, 1'b0});
   assign b_addr = bitrev({rd_cnt, 1'b1});
   assign a_word = mem[{rd_bank, a_addr}];
   assign b_word = mem[{rd_bank, b_addr}];

   always_comb begin
      bank_st_nx[0] = bank_st[0];
      bank_st_nx[1] = bank_st[1];
      wr_bank_nx    = wr_bank;
      rd_bank_nx    = rd_bank;
      wr_cnt_nx     = wr_cnt;
      rd_cnt_nx     = rd_cnt;

      if (wr_fire) begin
         if (wr_cnt == WR_LAST) begin
            wr_cnt_nx           = '0;
            bank_st_nx[wr_bank] = FULL;
            wr_bank_nx          = ~wr_bank;
         end else begin
            wr_cnt_nx = wr_cnt + LOG2N'(1);
         end
      end

      // The reader only ever touches a FULL bank and the writer a FREE one,
      // so both updates can land on the same edge without conflict.
      if (rd_fire) begin
         if (rd_cnt == RD_LAST) begin
            rd_cnt_nx           = '0;
            bank_st_nx[rd_bank] = FREE;
            rd_bank_nx          = ~rd_bank;
         end else begin
            rd_cnt_nx = rd_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_st[0] <= FREE;
         bank_st[1] <= FREE;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
      end else begin
         bank_st[0] <= bank_st_nx[0];
         bank_st[1] <= bank_st_nx[1];
         wr_bank    <= wr_bank_nx;
         rd_bank    <= rd_bank_nx;
         wr_cnt     <= wr_cnt_nx;
         rd_cnt     <= rd_cnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[{wr_bank, wr_cnt}] <= {bus.in_re, bus.in_im};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov   <= 1'b0;
         ar   <= '0;
         ai   <= '0;
         br   <= '0;
         bi   <= '0;
         idx  <= '0;
         last <= 1'b0;
      end else if (load) begin
         if (rd_avail) begin
            ov   <= 1'b1;
            ar   <= a_word[W-1:NBITS];
            ai   <= a_word[NBITS-1:0];
            br   <= b_word[W-1:NBITS];
            bi   <= b_word[NBITS-1:0];
            idx  <= rd_cnt;
            last <= (rd_cnt == RD_LAST);
         end else begin
            ov <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = ov;
   assign bus.out_ar    = ar;
   assign bus.out_ai    = ai;
   assign bus.out_br    = br;
   assign bus.out_bi    = bi;
   assign bus.out_idx   = idx;
   assign bus.out_last  = last;
endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_loader.sv
`default_nettype none
// Scoreboard bench for fft_bitrev_loader: random and directed frames checked
// against a bit-reversal model; a small LOG2N=2 instance is checked directly.
module tb_fft_bitrev_loader;
   localparam int NB = 16;
   localparam int LG = 4;
   localparam int N  = 1 << LG;
   localparam int H  = N / 2;

   typedef logic [4*NB+LG-1:0] pair_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_bitrev_loader_if #(.NBITS(NB), .LOG2N(LG)) bus ();
   fft_bitrev_loader #(.NBITS(NB), .LOG2N(LG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   fft_bitrev_loader_if #(.NBITS(NB), .LOG2N(2)) bus2 ();
   fft_bitrev_loader #(.NBITS(NB), .LOG2N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   int n_cmp = 0;
   int n_fail = 0;
   int rdy_mode = 0;
   bit chk_rdy = 0;

   logic [2*NB-1:0] frame_buf [$];
   pair_t           sb [$];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int rev(input int v, input int bits);
      int r = 0;
      int x = v;
      for (int i = 0; i < bits; i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   task automatic model_accept(input logic [NB-1:0] re, input logic [NB-1:0] im);
      frame_buf.push_back({re, im});
      if (frame_buf.size() == N) begin
         for (int k = 0; k < H; k++) begin
            logic [2*NB-1:0] a, b;
            logic [LG-2:0]   ik;
            a  = frame_buf[rev(2*k, LG)];
            b  = frame_buf[rev(2*k+1, LG)];
            ik = k[LG-2:0];
            sb.push_back({a, b, ik, (k == H-1)});
         end
         frame_buf.delete();
      end
   endtask

   function automatic logic [NB-1:0] rnd_sample();
      case ($urandom_range(7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         default: return NB'($urandom);
      endcase
   endfunction

   // Entry and exit at posedge+1; in_valid is low again on return.
   task automatic send(input logic [NB-1:0] re, input logic [NB-1:0] im, input int pct);
      int  guard = 0;
      bit  done = 0;
      bit  hs;
      while (!done) begin
         if (int'($urandom_range(99)) < pct) begin
            bus.in_valid = 1'b1;
            bus.in_re    = re;
            bus.in_im    = im;
         end else begin
            bus.in_valid = 1'b0;
            bus.in_re    = NB'($urandom);
            bus.in_im    = NB'($urandom);
         end
         @(negedge clk);
         hs = bus.in_valid && bus.in_ready;
         if (chk_rdy) check("in_ready_b2b", bus.in_ready, 1);
         if (hs) model_accept(re, im);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         guard++;
         if (hs) done = 1;
         else if (guard > 3000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=%0d for %0d cycles required 1", bus.in_ready, guard);
            done = 1;
         end
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         cycles(1);
         n++;
      end
      check("drain_left", sb.size(), 0);
      cycles(4);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("reset_outputs",
            {bus.out_valid, bus.out_ar, bus.out_ai, bus.out_br, bus.out_bi, bus.out_idx, bus.out_last}, 0);
      sb.delete();
      frame_buf.delete();
      bus.in_valid = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", bus.in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pop-and-compare on each accepted pair; frozen outputs while stalled.
   initial begin
      pair_t cur, snap, exp;
      bit stall = 0;
      forever begin
         @(negedge clk);
         cur = {bus.out_ar, bus.out_ai, bus.out_br, bus.out_bi, bus.out_idx, bus.out_last};
         if (!rst_n) begin
            stall = 0;
         end else begin
            if (stall) check("hold", {bus.out_valid, cur}, {1'b1, snap});
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_pair: got %h, no pair expected", cur);
               end else begin
                  exp = sb.pop_front();
                  check("pair", cur, exp);
               end
            end
            stall = bus.out_valid && !bus.out_ready;
            snap  = cur;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000 required earlier finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;
      bus2.in_valid = 1'b0;
      bus2.in_re    = '0;
      bus2.in_im    = '0;
      bus2.out_ready = 1'b1;

      #12;
      check("reset_outputs",
            {bus.out_valid, bus.out_ar, bus.out_ai, bus.out_br, bus.out_bi, bus.out_idx, bus.out_last}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Single ordered frame and first-pair latency
      for (int k = 0; k < N; k++) send(NB'(k), NB'(-k), 100);
      @(negedge clk);
      check("latency_early", bus.out_valid, 0);
      @(negedge clk);
      check("latency_first", bus.out_valid, 1);
      @(posedge clk);
      #1;
      drain(100);

      // Back-to-back frames, in_ready must stay high
      chk_rdy = 1;
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < N; k++) send(NB'(100*f + k), NB'(-(100*f + k)), 100);
      chk_rdy = 0;
      drain(100);

      // Downstream stall during readout while a second frame fills
      for (int k = 0; k < N; k++) send(NB'(300 + k), NB'(k), 100);
      cycles(2);
      rdy_mode = 2;
      fork
         begin
            cycles(20);
            rdy_mode = 0;
         end
         begin
            for (int k = 0; k < N; k++) send(NB'(400 + k), NB'(7 * k), 100);
            @(negedge clk);
            check("ready_blocked", bus.in_ready, 0);
            @(posedge clk);
            #1;
         end
      join
      for (int k = 0; k < N; k++) send(NB'(500 + k), NB'(-3 * k), 100);
      drain(200);

      // Random traffic on both sides
      rdy_mode = 1;
      for (int f = 0; f < 10; f++)
         for (int k = 0; k < N; k++) send(rnd_sample(), rnd_sample(), 50);
      drain(3000);
      rdy_mode = 0;
      cycles(2);

      // Reset mid-frame, then mid-readout
      for (int k = 0; k < 5; k++) send(NB'(900 + k), NB'(k), 100);
      do_reset();
      for (int k = 0; k < N; k++) send(rnd_sample(), rnd_sample(), 100);
      drain(100);
      rdy_mode = 2;
      for (int k = 0; k < N; k++) send(rnd_sample(), rnd_sample(), 100);
      cycles(3);
      check("valid_before_reset", bus.out_valid, 1);
      do_reset();
      rdy_mode = 0;
      cycles(3);
      check("idle_after_reset", bus.out_valid, 0);
      for (int k = 0; k < N; k++) send(rnd_sample(), rnd_sample(), 100);
      drain(100);

      // LOG2N=2 instance: inputs 0..3 -> (0,2),(1,3)
      for (int k = 0; k < 4; k++) begin
         int g = 0;
         bus2.in_valid = 1'b1;
         bus2.in_re    = NB'(k);
         bus2.in_im    = NB'(-k);
         do begin
            @(negedge clk);
            g++;
         end while (!bus2.in_ready && g < 20);
         check("n4_in_ready", bus2.in_ready, 1);
         @(posedge clk);
         #1;
      end
      bus2.in_valid = 1'b0;
      begin
         int got = 0;
         int g = 0;
         logic [4*NB+1:0] e;
         while (got < 2 && g < 20) begin
            @(negedge clk);
            g++;
            if (bus2.out_valid) begin
               e = {NB'(got), NB'(-got), NB'(got + 2), NB'(-(got + 2)), 1'(got), (got == 1)};
               check("n4_pair", {bus2.out_ar, bus2.out_ai, bus2.out_br, bus2.out_bi,
                                 bus2.out_idx, bus2.out_last}, e);
               got++;
            end
         end
         if (got < 2) check("n4_pair_count", got, 2);
         @(negedge clk);
         check("n4_idle", bus2.out_valid, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
